// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, FSM states and default width.
package fetch_stage_pkg;

    localparam int unsigned FETCH_WIDTH = 16;
    localparam logic [15:0] NOP_INST    = 16'h0800;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_FULL   = 3'd3,
        S_HALTED = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_buf.sv
// One-entry skid register holding a fetched word and its PC+2 while decode is stalled.
module fetch_buf
    import fetch_stage_pkg::*;
#(
    parameter int unsigned WIDTH = FETCH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_pc2,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_pc2
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_pc2;

    // Skid entry: clear (unload or flush) wins over a new load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= {WIDTH{1'b0}};
            r_pc2   <= {WIDTH{1'b0}};
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc2   <= i_pc2;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc2   = r_pc2;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch controller with IF/ID pipeline register; single outstanding imem read,
// drives the PC hold input so the PC advances only when a fetched word is accepted.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = FETCH_WIDTH,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fetch_addr,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_rd,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             imem_done,
    input  logic             imem_stall,
    input  logic             id_stall,
    input  logic             flush,
    input  logic             halt,
    output logic [WIDTH-1:0] inst_out,
    output logic [WIDTH-1:0] pc2_out,
    output logic             inst_valid,
    output logic             pc_hold,
    output logic             err
);

    localparam logic [WIDTH-1:0] NOP_W        = WIDTH'(NOP_INST);
    localparam logic [WIDTH-1:0] PC_INC       = {{(WIDTH-2){1'b0}}, 2'b10};
    localparam logic [15:0]      TIMEOUT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    fetch_state_t     r_state;
    fetch_state_t     w_next_state;
    logic [WIDTH-1:0] r_inst;
    logic [WIDTH-1:0] r_pc2;
    logic             r_valid;
    logic             r_err;
    logic             r_drop;
    logic             r_halted;
    logic [15:0]      r_timer;

    logic             w_halt_req;
    logic             w_can_load;
    logic             w_capture;
    logic             w_ifid_load;
    logic             w_ifid_from_buf;
    logic             w_buf_load;
    logic             w_buf_clear;
    logic             w_set_err;
    logic             w_drop_set;
    logic             w_drop_clr;
    logic [WIDTH-1:0] w_fetch_pc2;
    logic [WIDTH-1:0] w_ifid_data;
    logic [WIDTH-1:0] w_ifid_pc2;
    logic             w_buf_valid;
    logic [WIDTH-1:0] w_buf_data;
    logic [WIDTH-1:0] w_buf_pc2;

    assign imem_addr   = fetch_addr;
    assign w_halt_req  = halt | r_halted;
    assign w_can_load  = !r_valid || !id_stall;
    assign w_fetch_pc2 = fetch_addr + PC_INC;
    assign w_ifid_data = w_ifid_from_buf ? w_buf_data : imem_data;
    assign w_ifid_pc2  = w_ifid_from_buf ? w_buf_pc2 : w_fetch_pc2;

    fetch_buf #(.WIDTH(WIDTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_data  (imem_data),
        .i_pc2   (w_fetch_pc2),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data),
        .o_pc2   (w_buf_pc2)
    );

    // Next-state, memory request, PC hold and datapath control.
    always_comb begin
        w_next_state    = r_state;
        imem_rd         = 1'b0;
        pc_hold         = 1'b1;
        w_capture       = 1'b0;
        w_ifid_load     = 1'b0;
        w_ifid_from_buf = 1'b0;
        w_buf_load      = 1'b0;
        w_buf_clear     = 1'b0;
        w_set_err       = 1'b0;
        w_drop_set      = 1'b0;
        w_drop_clr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    pc_hold = 1'b0;
                end else begin
                    pc_hold = 1'b1;
                end
                w_next_state = w_halt_req ? S_HALTED : S_REQ;
            end
            S_REQ: begin
                if (flush) begin
                    pc_hold = 1'b0;
                end else if (w_halt_req) begin
                    w_next_state = S_HALTED;
                end else if (fetch_addr[0]) begin
                    w_set_err    = 1'b1;
                    w_next_state = S_HALTED;
                end else begin
                    imem_rd = 1'b1;
                    if (imem_stall) begin
                        w_next_state = S_REQ;
                    end else if (imem_done) begin
                        w_capture = 1'b1;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    pc_hold = 1'b0;
                    if (imem_done) begin
                        w_drop_clr   = 1'b1;
                        w_next_state = w_halt_req ? S_HALTED : S_REQ;
                    end else begin
                        w_drop_set = 1'b1;
                    end
                end else if (imem_done) begin
                    if (r_drop) begin
                        w_drop_clr   = 1'b1;
                        w_next_state = w_halt_req ? S_HALTED : S_REQ;
                    end else begin
                        w_capture = 1'b1;
                    end
                end else if ((TIMEOUT != 0) && (r_timer == TIMEOUT_LAST)) begin
                    w_set_err    = 1'b1;
                    w_next_state = S_HALTED;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_FULL: begin
                if (flush) begin
                    pc_hold      = 1'b0;
                    w_buf_clear  = 1'b1;
                    w_next_state = w_halt_req ? S_HALTED : S_REQ;
                end else if (!id_stall) begin
                    pc_hold         = 1'b0;
                    w_buf_clear     = 1'b1;
                    w_ifid_load     = w_buf_valid;
                    w_ifid_from_buf = 1'b1;
                    w_next_state    = w_halt_req ? S_HALTED : S_REQ;
                end else begin
                    w_next_state = S_FULL;
                end
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // A completed, non-discarded read goes to IF/ID if decode can take it, else to the skid entry.
        if (w_capture) begin
            if (w_can_load) begin
                w_ifid_load  = 1'b1;
                pc_hold      = 1'b0;
                w_next_state = w_halt_req ? S_HALTED : S_REQ;
            end else begin
                w_buf_load   = 1'b1;
                w_next_state = S_FULL;
            end
        end else begin
            w_buf_load = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // IF/ID register: flush beats load, load beats decode consumption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst  <= NOP_W;
            r_pc2   <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else if (flush) begin
            r_inst  <= NOP_W;
            r_valid <= 1'b0;
        end else if (w_ifid_load) begin
            r_inst  <= w_ifid_data;
            r_pc2   <= w_ifid_pc2;
            r_valid <= 1'b1;
        end else if (r_valid && !id_stall) begin
            r_inst  <= NOP_W;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Sticky error/halt flags, discard marker for a flushed in-flight read, and WAIT watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err    <= 1'b0;
            r_halted <= 1'b0;
            r_drop   <= 1'b0;
            r_timer  <= 16'd0;
        end else begin
            r_err    <= r_err | w_set_err;
            r_halted <= r_halted | halt;
            if (w_drop_set) begin
                r_drop <= 1'b1;
            end else if (w_drop_clr) begin
                r_drop <= 1'b0;
            end else begin
                r_drop <= r_drop;
            end
            if (r_state == S_WAIT) begin
                r_timer <= r_timer + 16'd1;
            end else begin
                r_timer <= 16'd0;
            end
        end
    end

    assign inst_out   = r_inst;
    assign pc2_out    = r_pc2;
    assign inst_valid = r_valid;
    assign err        = r_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small PC model driven by pc_hold.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [15:0] fetch_addr;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_done;
    logic        imem_stall;
    logic        id_stall;
    logic        flush;
    logic        halt;
    logic [15:0] inst_out;
    logic [15:0] pc2_out;
    logic        inst_valid;
    logic        pc_hold;
    logic        err;
    logic [15:0] target;
    int          n_checks;
    int          n_pass;

    fetch_stage #(.WIDTH(16), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_addr (fetch_addr),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .imem_done  (imem_done),
        .imem_stall (imem_stall),
        .id_stall   (id_stall),
        .flush      (flush),
        .halt       (halt),
        .inst_out   (inst_out),
        .pc2_out    (pc2_out),
        .inst_valid (inst_valid),
        .pc_hold    (pc_hold),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Let combinational outputs settle after inputs change.
    task automatic settle();
        #2;
    endtask

    // Advance one clock; model the PC: load target on flush, else +2, unless held.
    task automatic tick();
        logic h;
        logic f;
        h = pc_hold;
        f = flush;
        @(posedge clk);
        #1;
        if (!h) fetch_addr = f ? target : fetch_addr + 16'd2;
    endtask

    task automatic drive(input logic d, input logic [15:0] data, input logic ids,
                         input logic fl, input logic hl);
        imem_done = d;
        imem_data = data;
        id_stall  = ids;
        flush     = fl;
        halt      = hl;
        settle();
    endtask

    task automatic do_reset(input logic [15:0] addr);
        rst        = 1'b1;
        fetch_addr = addr;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        fetch_addr = 16'h0000;
        target     = 16'h0000;
        imem_stall = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        check_eq("rst_inst", inst_out, 16'h0800);
        check_eq("rst_pc2", pc2_out, 16'h0000);
        check_eq("rst_valid", {15'd0, inst_valid}, 16'd0);
        check_eq("rst_err", {15'd0, err}, 16'd0);
        check_eq("rst_hold", {15'd0, pc_hold}, 16'd1);
        check_eq("rst_rd", {15'd0, imem_rd}, 16'd0);

        tick();
        rst = 1'b0;
        tick();

        // Back-to-back hits at 0x0000 and 0x0002.
        drive(1'b1, 16'h4001, 1'b0, 1'b0, 1'b0);
        check_eq("hit1_rd", {15'd0, imem_rd}, 16'd1);
        check_eq("hit1_hold", {15'd0, pc_hold}, 16'd0);
        tick();
        check_eq("hit1_inst", inst_out, 16'h4001);
        check_eq("hit1_pc2", pc2_out, 16'h0002);
        check_eq("hit1_valid", {15'd0, inst_valid}, 16'd1);
        drive(1'b1, 16'h4002, 1'b0, 1'b0, 1'b0);
        check_eq("hit2_addr", imem_addr, 16'h0002);
        check_eq("hit2_hold", {15'd0, pc_hold}, 16'd0);
        tick();
        check_eq("hit2_inst", inst_out, 16'h4002);
        check_eq("hit2_pc2", pc2_out, 16'h0004);

        // Flush in REQ redirects to 0x0010.
        target = 16'h0010;
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check_eq("flreq_rd", {15'd0, imem_rd}, 16'd0);
        check_eq("flreq_hold", {15'd0, pc_hold}, 16'd0);
        tick();
        check_eq("flreq_valid", {15'd0, inst_valid}, 16'd0);
        check_eq("flreq_inst", inst_out, 16'h0800);

        // Three-cycle miss at 0x0010.
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_eq("miss_addr", imem_addr, 16'h0010);
        check_eq("miss_rd", {15'd0, imem_rd}, 16'd1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
            check_eq("miss_wait_rd", {15'd0, imem_rd}, 16'd0);
            check_eq("miss_wait_hold", {15'd0, pc_hold}, 16'd1);
            tick();
        end
        drive(1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        check_eq("miss_done_hold", {15'd0, pc_hold}, 16'd0);
        tick();
        check_eq("miss_inst", inst_out, 16'hA5A5);
        check_eq("miss_pc2", pc2_out, 16'h0012);

        // Decode stall: 0x1234 goes to the skid entry.
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        check_eq("stall_hold", {15'd0, pc_hold}, 16'd1);
        tick();
        check_eq("stall_inst", inst_out, 16'hA5A5);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check_eq("full_rd", {15'd0, imem_rd}, 16'd0);
        check_eq("full_hold", {15'd0, pc_hold}, 16'd1);
        tick();
        check_eq("full_inst", inst_out, 16'hA5A5);
        check_eq("full_pc2", pc2_out, 16'h0012);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_eq("unload_hold", {15'd0, pc_hold}, 16'd0);
        tick();
        check_eq("unload_inst", inst_out, 16'h1234);
        check_eq("unload_pc2", pc2_out, 16'h0014);

        // Flush in WAIT, late 0xDEAD must be discarded.
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_eq("flw_req_addr", imem_addr, 16'h0014);
        tick();
        check_eq("flw_consumed", {15'd0, inst_valid}, 16'd0);
        target = 16'h0040;
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check_eq("flw_hold", {15'd0, pc_hold}, 16'd0);
        tick();
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        check_eq("flw_drop_hold", {15'd0, pc_hold}, 16'd1);
        tick();
        check_eq("flw_inst", inst_out, 16'h0800);
        check_eq("flw_valid", {15'd0, inst_valid}, 16'd0);
        drive(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
        check_eq("flw_new_addr", imem_addr, 16'h0040);
        check_eq("flw_new_rd", {15'd0, imem_rd}, 16'd1);
        tick();
        check_eq("flw_new_inst", inst_out, 16'h5555);
        check_eq("flw_new_pc2", pc2_out, 16'h0042);

        // PC+2 wraps at 0xFFFE.
        target = 16'hFFFE;
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
        check_eq("wrap_addr", imem_addr, 16'hFFFE);
        tick();
        check_eq("wrap_inst", inst_out, 16'h7777);
        check_eq("wrap_pc2", pc2_out, 16'h0000);

        // Halt during WAIT: in-flight read completes, then HALTED.
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 16'h6666, 1'b0, 1'b0, 1'b0);
        check_eq("halt_cap_hold", {15'd0, pc_hold}, 16'd0);
        tick();
        check_eq("halt_inst", inst_out, 16'h6666);
        check_eq("halt_pc2", pc2_out, 16'h0002);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_eq("halted_rd", {15'd0, imem_rd}, 16'd0);
        check_eq("halted_hold", {15'd0, pc_hold}, 16'd1);
        tick();
        check_eq("halted_drain", {15'd0, inst_valid}, 16'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_eq("halted_rd2", {15'd0, imem_rd}, 16'd0);

        // Misaligned fetch.
        do_reset(16'h0003);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_eq("mis_rd", {15'd0, imem_rd}, 16'd0);
        tick();
        check_eq("mis_err", {15'd0, err}, 16'd1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_eq("mis_rd2", {15'd0, imem_rd}, 16'd0);
        check_eq("mis_hold", {15'd0, pc_hold}, 16'd1);

        // Watchdog: no done for 15 WAIT cycles.
        do_reset(16'h0020);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_eq("to_rd", {15'd0, imem_rd}, 16'd1);
        tick();
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
            tick();
        end
        check_eq("to_err_early", {15'd0, err}, 16'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("to_err", {15'd0, err}, 16'd1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_eq("to_rd_off", {15'd0, imem_rd}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
